// File: rtl/video_mem_writer_pkg.sv
// Shared geometry and encodings for the 16x12 cell video memory.
// Both the write engine and the VGA read-side adapter import this package,
// so they agree on the grid size and the row-major mapping addr = y*WIDTH_MEM + x.
package video_mem_writer_pkg;

    localparam int WIDTH_MEM  = 16;  // cells per row
    localparam int HEIGHT_MEM = 12;  // rows
    localparam int COLOR_W    = 3;   // bits per cell colour
    localparam int ADDR_W     = 8;   // memory address width
    localparam int COORD_W    = 5;   // request coordinate width
    localparam int NUM_CELLS  = WIDTH_MEM * HEIGHT_MEM;

    // Limits expressed at coordinate width for direct compares
    localparam logic [COORD_W-1:0] WIDTH_LIM  = COORD_W'(WIDTH_MEM);
    localparam logic [COORD_W-1:0] HEIGHT_LIM = COORD_W'(HEIGHT_MEM);
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NUM_CELLS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Row-major cell address, computed at ADDR_W bits
    function automatic logic [ADDR_W-1:0] cell_addr(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y
    );
        return (ADDR_W'(y) * ADDR_W'(WIDTH_MEM)) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/video_mem_writer_cell_addr_calc.sv
// cell_addr_calc: combinational (x,y) -> row-major memory address plus a
// range flag. Shared with future read-side logic.
// Ports:
//   x, y      in   cell column / row
//   addr      out  y*WIDTH_MEM + x (meaningful only when in_range)
//   in_range  out  1 when x < WIDTH_MEM and y < HEIGHT_MEM
module cell_addr_calc
    import video_mem_writer_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr,
    output logic               in_range
);

    // Address and range flag
    always_comb begin
        addr     = cell_addr(x, y);
        in_range = (x < WIDTH_LIM) && (y < HEIGHT_LIM);
    end

endmodule

// File: rtl/video_mem_writer.sv
// video_mem_writer: write-side engine for the video memory.
// Accepts single-cell writes over a valid/ready handshake and a full-screen
// clear that sweeps every cell with a latched fill colour.
// Ports:
//   Clock, Reset          clock, synchronous active-low reset
//   reqValid/reqReady     cell write handshake; reqX/reqY/reqColor payload
//   clearStart/clearColor start pulse and fill colour for a clear sweep
//   busy                  clear sweep in progress
//   clearDone             one-cycle pulse after the last clear write
//   errOutOfRange         one-cycle pulse for an accepted out-of-range request
//   memWe/memAddr/memData memory write port (registered)
module video_mem_writer
    import video_mem_writer_pkg::*;
(
    input  logic               Clock,
    input  logic               Reset,
    input  logic               reqValid,
    output logic               reqReady,
    input  logic [COORD_W-1:0] reqX,
    input  logic [COORD_W-1:0] reqY,
    input  logic [COLOR_W-1:0] reqColor,
    input  logic               clearStart,
    input  logic [COLOR_W-1:0] clearColor,
    output logic               busy,
    output logic               clearDone,
    output logic               errOutOfRange,
    output logic               memWe,
    output logic [ADDR_W-1:0]  memAddr,
    output logic [COLOR_W-1:0] memData
);

    state_e              state_q, state_d;
    logic [COLOR_W-1:0]  clear_color_q, clear_color_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [COLOR_W-1:0]  mem_data_q, mem_data_d;
    logic                busy_q, busy_d;
    logic                clear_done_q, clear_done_d;
    logic                err_q, err_d;

    logic [ADDR_W-1:0]   req_addr_s;
    logic                req_in_range_s;

    cell_addr_calc u_addr_calc (
        .x        (reqX),
        .y        (reqY),
        .addr     (req_addr_s),
        .in_range (req_in_range_s)
    );

    // Ready only in IDLE, out of reset, and when no clear is starting
    always_comb begin
        reqReady = Reset && (state_q == ST_IDLE) && !clearStart;
    end

    // Next-state and next-output logic. During a sweep the registered memAddr
    // doubles as the clear counter: it always holds the address being written.
    always_comb begin
        state_d       = state_q;
        clear_color_d = clear_color_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_data_d    = mem_data_q;
        busy_d        = 1'b0;
        clear_done_d  = 1'b0;
        err_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clearStart) begin
                    // First sweep write appears on the very next cycle
                    state_d       = ST_CLEAR;
                    clear_color_d = clearColor;
                    mem_we_d      = 1'b1;
                    mem_addr_d    = {ADDR_W{1'b0}};
                    mem_data_d    = clearColor;
                    busy_d        = 1'b1;
                end else if (reqValid) begin
                    if (req_in_range_s) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = req_addr_s;
                        mem_data_d = reqColor;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (mem_addr_q == LAST_ADDR) begin
                    state_d      = ST_IDLE;
                    clear_done_d = 1'b1;
                end else begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    mem_data_d = clear_color_q;
                    busy_d     = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q       <= ST_IDLE;
            clear_color_q <= {COLOR_W{1'b0}};
            mem_we_q      <= 1'b0;
            mem_addr_q    <= {ADDR_W{1'b0}};
            mem_data_q    <= {COLOR_W{1'b0}};
            busy_q        <= 1'b0;
            clear_done_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            clear_color_q <= clear_color_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
            busy_q        <= busy_d;
            clear_done_q  <= clear_done_d;
            err_q         <= err_d;
        end
    end

    assign memWe         = mem_we_q;
    assign memAddr       = mem_addr_q;
    assign memData       = mem_data_q;
    assign busy          = busy_q;
    assign clearDone     = clear_done_q;
    assign errOutOfRange = err_q;

endmodule

// File: tb/tb_video_mem_writer.sv
// Directed self-checking bench for video_mem_writer.
module tb_video_mem_writer;

    logic       Clock;
    logic       Reset;
    logic       reqValid;
    logic       reqReady;
    logic [4:0] reqX;
    logic [4:0] reqY;
    logic [2:0] reqColor;
    logic       clearStart;
    logic [2:0] clearColor;
    logic       busy;
    logic       clearDone;
    logic       errOutOfRange;
    logic       memWe;
    logic [7:0] memAddr;
    logic [2:0] memData;

    int errors = 0;
    int checks = 0;

    video_mem_writer dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .reqValid      (reqValid),
        .reqReady      (reqReady),
        .reqX          (reqX),
        .reqY          (reqY),
        .reqColor      (reqColor),
        .clearStart    (clearStart),
        .clearColor    (clearColor),
        .busy          (busy),
        .clearDone     (clearDone),
        .errOutOfRange (errOutOfRange),
        .memWe         (memWe),
        .memAddr       (memAddr),
        .memData       (memData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; reqValid = 1'b1; reqX = 5'd3; reqY = 5'd2; reqColor = 3'd5;
        clearStart = 1'b0; clearColor = 3'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({memWe, busy, clearDone, errOutOfRange, memAddr, memData, reqReady} !== 15'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: we=%b busy=%b done=%b err=%b addr=%0d data=%0d rdy=%b, expected all 0",
                         i, memWe, busy, clearDone, errOutOfRange, memAddr, memData, reqReady);
            end
        end
        reqValid = 1'b0;
        Reset = 1'b1;
        #1;
        checks++;
        if (reqReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", reqReady);
        end
    endtask

    task automatic test_single_write();
        reqX = 5'd3; reqY = 5'd2; reqColor = 3'd5; reqValid = 1'b1;
        #1;
        checks++;
        if (reqReady !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b expected 1", reqReady);
        end
        tick();
        reqValid = 1'b0;
        checks++;
        if ({memWe, memAddr, memData, errOutOfRange} !== {1'b1, 8'd35, 3'd5, 1'b0}) begin
            errors++;
            $display("FAIL single_write: we=%b addr=%0d data=%0d err=%b expected we=1 addr=35 data=5 err=0",
                     memWe, memAddr, memData, errOutOfRange);
        end
        tick();
        checks++;
        if ({memWe, memAddr, memData} !== {1'b0, 8'd35, 3'd5}) begin
            errors++;
            $display("FAIL single_idle: we=%b addr=%0d data=%0d expected we=0 addr=35 data=5 (hold)",
                     memWe, memAddr, memData);
        end
    endtask

    task automatic test_back_to_back();
        reqX = 5'd0; reqY = 5'd0; reqColor = 3'd1; reqValid = 1'b1;
        tick();
        reqX = 5'd15; reqY = 5'd11; reqColor = 3'd7;
        checks++;
        if ({memWe, memAddr, memData} !== {1'b1, 8'd0, 3'd1}) begin
            errors++;
            $display("FAIL b2b_first: we=%b addr=%0d data=%0d expected we=1 addr=0 data=1", memWe, memAddr, memData);
        end
        tick();
        reqValid = 1'b0;
        checks++;
        if ({memWe, memAddr, memData} !== {1'b1, 8'd191, 3'd7}) begin
            errors++;
            $display("FAIL b2b_second: we=%b addr=%0d data=%0d expected we=1 addr=191 data=7", memWe, memAddr, memData);
        end
        tick();
        checks++;
        if (memWe !== 1'b0) begin
            errors++;
            $display("FAIL b2b_after: we=%b expected 0", memWe);
        end
    endtask

    task automatic test_out_of_range();
        reqX = 5'd16; reqY = 5'd0; reqColor = 3'd4; reqValid = 1'b1;
        #1;
        checks++;
        if (reqReady !== 1'b1) begin
            errors++;
            $display("FAIL oor_ready: got %b expected 1", reqReady);
        end
        tick();
        reqValid = 1'b0;
        checks++;
        if ({memWe, errOutOfRange, memAddr, memData} !== {1'b0, 1'b1, 8'd191, 3'd7}) begin
            errors++;
            $display("FAIL oor_x: we=%b err=%b addr=%0d data=%0d expected we=0 err=1 addr=191 data=7",
                     memWe, errOutOfRange, memAddr, memData);
        end
        tick();
        checks++;
        if ({memWe, errOutOfRange} !== 2'b00) begin
            errors++;
            $display("FAIL oor_pulse: we=%b err=%b expected 0 0", memWe, errOutOfRange);
        end
        reqX = 5'd0; reqY = 5'd12; reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        checks++;
        if ({memWe, errOutOfRange} !== 2'b01) begin
            errors++;
            $display("FAIL oor_y: we=%b err=%b expected we=0 err=1", memWe, errOutOfRange);
        end
    endtask

    task automatic test_clear();
        reqX = 5'd5; reqY = 5'd1; reqColor = 3'd6; reqValid = 1'b1;
        clearColor = 3'd2; clearStart = 1'b1;
        #1;
        checks++;
        if (reqReady !== 1'b0) begin
            errors++;
            $display("FAIL clear_start_ready: got %b expected 0", reqReady);
        end
        tick();
        clearStart = 1'b0;
        clearColor = 3'd3;
        for (int i = 0; i < 192; i++) begin
            checks++;
            if ({memWe, busy, clearDone, reqReady, memAddr, memData} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'(i), 3'd2}) begin
                errors++;
                $display("FAIL clear_sweep step %0d: we=%b busy=%b done=%b rdy=%b addr=%0d data=%0d expected we=1 busy=1 done=0 rdy=0 addr=%0d data=2",
                         i, memWe, busy, clearDone, reqReady, memAddr, memData, i);
            end
            // A restart attempt mid-sweep must be ignored
            clearStart = (i == 50);
            clearColor = (i == 50) ? 3'd5 : 3'd3;
            tick();
        end
        clearStart = 1'b0;
        checks++;
        if ({clearDone, busy, memWe, reqReady} !== 4'b1001) begin
            errors++;
            $display("FAIL clear_done: done=%b busy=%b we=%b rdy=%b expected done=1 busy=0 we=0 rdy=1",
                     clearDone, busy, memWe, reqReady);
        end
        tick();
        reqValid = 1'b0;
        checks++;
        if ({memWe, memAddr, memData, clearDone} !== {1'b1, 8'd21, 3'd6, 1'b0}) begin
            errors++;
            $display("FAIL clear_held_req: we=%b addr=%0d data=%0d done=%b expected we=1 addr=21 data=6 done=0",
                     memWe, memAddr, memData, clearDone);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        clearColor = 3'd1; clearStart = 1'b1;
        tick();
        clearStart = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        checks++;
        if ({memAddr, busy} !== {8'd100, 1'b1}) begin
            errors++;
            $display("FAIL midclear_pos: addr=%0d busy=%b expected addr=100 busy=1", memAddr, busy);
        end
        Reset = 1'b0;
        tick();
        checks++;
        if ({busy, memWe, clearDone, memAddr} !== 11'd0) begin
            errors++;
            $display("FAIL midclear_abort: busy=%b we=%b done=%b addr=%0d expected all 0", busy, memWe, clearDone, memAddr);
        end
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({clearDone, memWe, busy, reqReady} !== 4'b0001) begin
                errors++;
                $display("FAIL midclear_quiet cycle %0d: done=%b we=%b busy=%b rdy=%b expected 0 0 0 1",
                         i, clearDone, memWe, busy, reqReady);
            end
        end
        clearColor = 3'd4; clearStart = 1'b1;
        tick();
        clearStart = 1'b0;
        checks++;
        if ({memWe, memAddr, memData, busy} !== {1'b1, 8'd0, 3'd4, 1'b1}) begin
            errors++;
            $display("FAIL restart_first: we=%b addr=%0d data=%0d busy=%b expected we=1 addr=0 data=4 busy=1",
                     memWe, memAddr, memData, busy);
        end
        n = 0;
        while (clearDone !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 192) begin
            errors++;
            $display("FAIL restart_done_latency: clearDone after %0d cycles expected 192", n);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_out_of_range();
        test_clear();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
